// File: rtl/field_ctrl_pkg.sv
// field_ctrl_pkg
//   Shared encodings for the field-select controller and the flag decoder:
//   field codes, per-group first/last fields, mode_sel encodings, FSM states,
//   and the cursor-step helper used to walk a group with wrap-around.
package field_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_HOUR   = 2'b00,
    MODE_DATE   = 2'b01,
    MODE_CHRONO = 2'b10,
    MODE_INV    = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EDIT = 1'b1
  } state_e;

  localparam logic [3:0] FLD_HOUR_S = 4'd0;
  localparam logic [3:0] FLD_HOUR_M = 4'd1;
  localparam logic [3:0] FLD_HOUR_H = 4'd2;
  localparam logic [3:0] FLD_DATE_D = 4'd3;
  localparam logic [3:0] FLD_DATE_M = 4'd4;
  localparam logic [3:0] FLD_DATE_Y = 4'd5;
  localparam logic [3:0] FLD_CHR_S  = 4'd7;
  localparam logic [3:0] FLD_CHR_M  = 4'd8;
  localparam logic [3:0] FLD_CHR_H  = 4'd9;
  localparam logic [3:0] FLD_NONE   = 4'hF;

  function automatic logic [3:0] grp_first(input logic [1:0] mode);
    case (mode)
      MODE_HOUR:   return FLD_HOUR_S;
      MODE_DATE:   return FLD_DATE_D;
      MODE_CHRONO: return FLD_CHR_S;
      default:     return FLD_NONE;
    endcase
  endfunction

  function automatic logic [3:0] grp_last(input logic [1:0] mode);
    case (mode)
      MODE_HOUR:   return FLD_HOUR_H;
      MODE_DATE:   return FLD_DATE_Y;
      MODE_CHRONO: return FLD_CHR_H;
      default:     return FLD_NONE;
    endcase
  endfunction

  // Step one field forward or backward inside the group of 'mode', wrapping
  // at both ends. A code that does not belong to the group snaps to its first
  // field, so code 6 (the gap between date and chrono) can never appear.
  function automatic logic [3:0] fld_step(input logic [3:0] fld,
                                          input logic [1:0] mode,
                                          input logic       fwd);
    logic [3:0] first;
    logic [3:0] last;
    first = grp_first(mode);
    last  = grp_last(mode);
    if (fld < first || fld > last) return first;
    if (fwd) return (fld == last)  ? first : fld + 4'd1;
    else     return (fld == first) ? last  : fld - 4'd1;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// btn_edge
//   Rising-edge detector for one debounced button level.
//   Ports: clk, reset (sync, active-low), btn (level), rise (one-cycle event,
//   combinational from the current level and the registered history).
//   History resets to "pressed", so a button held through reset release must
//   be released and pressed again before it produces an event.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  logic btn_p1;

  always_ff @(posedge clk) begin
    if (!reset) btn_p1 <= 1'b1;
    else        btn_p1 <= btn;
  end

  assign rise = btn & ~btn_p1;

endmodule

// File: rtl/field_select_ctrl.sv
// field_select_ctrl
//   Edit-mode controller for a watch display: selects which field is being
//   edited, issues increment/decrement strobes and drives the blink phase.
//   Ports:
//     clk                 single clock, rising edge
//     reset               synchronous, active-low
//     mode_sel[1:0]       00 hour, 01 date, 10 chronometer, 11 invalid
//     edit_en             level request to enter/stay in edit
//     btn_left/right/up/down  debounced button levels
//     field_code[3:0]     selected field (0-5, 7-9), 15 when not editing
//     inc_pulse/dec_pulse one-cycle adjust strobes
//     blink               blank phase for the selected field
//     editing             high while in EDIT
//   Build option: define FIELD_TIMEOUT_EN to include the inactivity timeout
//   (TIMEOUT idle cycles in EDIT return to IDLE). Without it EDIT is left only
//   through edit_en = 0 or mode_sel = 11.
import field_ctrl_pkg::*;

module field_select_ctrl #(
  parameter int BLINK_DIV = 25_000_000,
  parameter int TIMEOUT   = 500_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode_sel,
  input  logic       edit_en,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [3:0] field_code,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       blink,
  output logic       editing
);

  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic ev_l, ev_r, ev_u, ev_d;

  btn_edge u_edge_left  (.clk(clk), .reset(reset), .btn(btn_left),  .rise(ev_l));
  btn_edge u_edge_right (.clk(clk), .reset(reset), .btn(btn_right), .rise(ev_r));
  btn_edge u_edge_up    (.clk(clk), .reset(reset), .btn(btn_up),    .rise(ev_u));
  btn_edge u_edge_down  (.clk(clk), .reset(reset), .btn(btn_down),  .rise(ev_d));

  state_e        state, state_nxt;
  logic          edit_p1;
  logic [1:0]    mode_p1;
  logic [3:0]    field_q, field_nxt;
  logic          inc_q, inc_nxt;
  logic          dec_q, dec_nxt;
  logic          blink_q, blink_nxt;
  logic [BW-1:0] bcnt, bcnt_nxt;
  logic          timeout;
  logic          edit_rise;
  logic          mode_chg;
  logic          lr_move;

  assign edit_rise = edit_en & ~edit_p1;
  assign mode_chg  = (mode_sel != mode_p1);
  // Simultaneous left+right cancel each other.
  assign lr_move   = ev_l ^ ev_r;

`ifdef FIELD_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] idle_cnt;
  logic          any_ev;

  assign any_ev  = ev_l | ev_r | ev_u | ev_d;
  assign timeout = (idle_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (!reset || state != ST_EDIT || any_ev) idle_cnt <= '0;
    else                                       idle_cnt <= idle_cnt + TW'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    field_nxt = field_q;
    inc_nxt   = 1'b0;
    dec_nxt   = 1'b0;
    blink_nxt = blink_q;
    bcnt_nxt  = bcnt;

    case (state)
      ST_IDLE: if (edit_rise && mode_sel != MODE_INV) state_nxt = ST_EDIT;
      ST_EDIT: if (!edit_en || mode_sel == MODE_INV || timeout) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with
    // 'editing'; the first EDIT cycle still shows NONE and the group's first
    // field is loaded one cycle later.
    if (state_nxt == ST_IDLE || state == ST_IDLE) begin
      field_nxt = FLD_NONE;
      blink_nxt = 1'b0;
      bcnt_nxt  = '0;
    end else begin
      if (mode_chg || field_q == FLD_NONE) field_nxt = grp_first(mode_sel);
      else if (lr_move)                    field_nxt = fld_step(field_q, mode_sel, ev_r);

      if (mode_chg || (field_q != FLD_NONE && lr_move)) begin
        blink_nxt = 1'b0;
        bcnt_nxt  = '0;
      end else if (bcnt == BLINK_LAST) begin
        blink_nxt = ~blink_q;
        bcnt_nxt  = '0;
      end else begin
        bcnt_nxt  = bcnt + BW'(1);
      end

      // Up+down together cancel; a group change swallows the strobe.
      inc_nxt = ev_u & ~ev_d & ~mode_chg;
      dec_nxt = ev_d & ~ev_u & ~mode_chg;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      edit_p1 <= 1'b1;
      mode_p1 <= MODE_HOUR;
      field_q <= FLD_NONE;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      blink_q <= 1'b0;
      bcnt    <= '0;
    end else begin
      state   <= state_nxt;
      edit_p1 <= edit_en;
      mode_p1 <= mode_sel;
      field_q <= field_nxt;
      inc_q   <= inc_nxt;
      dec_q   <= dec_nxt;
      blink_q <= blink_nxt;
      bcnt    <= bcnt_nxt;
    end
  end

  assign field_code = field_q;
  assign inc_pulse  = inc_q;
  assign dec_pulse  = dec_q;
  assign blink      = blink_q;
  assign editing    = (state == ST_EDIT);

endmodule

// File: tb/tb_field_select_ctrl.sv
// tb_field_select_ctrl
//   Directed bench for field_select_ctrl with BLINK_DIV = 4, TIMEOUT = 20.
//   Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_field_select_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode_sel;
  logic       edit_en;
  logic       btn_left, btn_right, btn_up, btn_down;
  logic [3:0] field_code;
  logic       inc_pulse, dec_pulse, blink, editing;

  int checks   = 0;
  int failures = 0;

  field_select_ctrl #(.BLINK_DIV(4), .TIMEOUT(20)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode_sel  (mode_sel),
    .edit_en   (edit_en),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .field_code(field_code),
    .inc_pulse (inc_pulse),
    .dec_pulse (dec_pulse),
    .blink     (blink),
    .editing   (editing)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Press and release a button: the move is visible right after the press edge.
  task automatic press_right();
    btn_right = 1'b1; tick();
    btn_right = 1'b0;
  endtask

  task automatic press_left();
    btn_left = 1'b1; tick();
    btn_left = 1'b0;
  endtask

  // Leave EDIT, then raise edit_en in the given mode. Returns one cycle after
  // the first field has been loaded.
  task automatic enter_edit(input logic [1:0] m);
    edit_en = 1'b0; tick();
    mode_sel = m; edit_en = 1'b1;
    tick();
    tick();
  endtask

  int npulse, ndec;

  initial begin
    reset = 1'b0; mode_sel = 2'b00; edit_en = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    tick(); tick();

    chk("rst_field", field_code, 15);
    chk("rst_editing", editing, 0);
    chk("rst_inc", inc_pulse, 0);
    chk("rst_dec", dec_pulse, 0);
    chk("rst_blink", blink, 0);
    reset = 1'b1;
    tick();

    // Date entry, blink cadence and inactivity timeout.
    mode_sel = 2'b01; edit_en = 1'b1;
    tick();
    chk("entry_editing", editing, 1);
    chk("entry_field_none", field_code, 15);
    for (int n = 1; n <= 20; n++) begin
      tick();
      case (n)
        1:  chk("entry_field_date", field_code, 3);
        3:  chk("blink_n3", blink, 0);
        4:  chk("blink_n4", blink, 1);
        7:  chk("blink_n7", blink, 1);
        8:  chk("blink_n8", blink, 0);
        19: chk("to_before_editing", editing, 1);
        20: begin
`ifdef FIELD_TIMEOUT_EN
          chk("to_editing", editing, 0);
          chk("to_field", field_code, 15);
`else
          chk("noto_editing", editing, 1);
          chk("noto_field", field_code, 3);
`endif
        end
        default: ;
      endcase
    end

    // Hour group navigation with wrap in both directions.
    enter_edit(2'b00);
    chk("hour_first", field_code, 0);
    press_right(); chk("hour_r1", field_code, 1); tick();
    press_right(); chk("hour_r2", field_code, 2);
    chk("blink_restart_move", blink, 0); tick();
    press_right(); chk("hour_wrap_fwd", field_code, 0); tick();
    press_left();  chk("hour_wrap_back", field_code, 2); tick();
    btn_left = 1'b1; btn_right = 1'b1; tick();
    chk("hour_lr_cancel", field_code, 2);
    btn_left = 1'b0; btn_right = 1'b0; tick();

    // Chrono adjust strobes.
    enter_edit(2'b10);
    chk("chr_first", field_code, 7);
    press_right(); chk("chr_field8", field_code, 8); tick();
    btn_up = 1'b1; npulse = 0; ndec = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) chk("up_pulse_timing", inc_pulse, 1);
      if (inc_pulse) npulse++;
      if (dec_pulse) ndec++;
    end
    chk("held_up_pulses", npulse, 1);
    chk("held_up_dec", ndec, 0);
    btn_up = 1'b0; tick();
    btn_up = 1'b1; btn_down = 1'b1; tick();
    chk("ud_cancel_inc", inc_pulse, 0);
    chk("ud_cancel_dec", dec_pulse, 0);
    tick();
    chk("ud_cancel_inc2", inc_pulse, 0);
    btn_up = 1'b0; btn_down = 1'b0; tick();
    btn_down = 1'b1; tick();
    chk("down_dec", dec_pulse, 1);
    chk("down_inc", inc_pulse, 0);
    tick();
    chk("down_dec_width", dec_pulse, 0);
    chk("chr_field_kept", field_code, 8);
    btn_down = 1'b0; tick();

    // Group change in EDIT, then invalid mode exits.
    enter_edit(2'b01);
    press_right(); tick();
    press_right(); chk("date_last", field_code, 5); tick();
    mode_sel = 2'b10; btn_up = 1'b1; tick();
    chk("mode_reload", field_code, 7);
    chk("mode_chg_no_inc", inc_pulse, 0);
    btn_up = 1'b0; tick();
    chk("mode_still_edit", editing, 1);
    mode_sel = 2'b11; tick();
    chk("inv_editing", editing, 0);
    chk("inv_field", field_code, 15);

    // Reset during EDIT with btn_right held.
    enter_edit(2'b00);
    btn_right = 1'b1; tick();
    chk("pre_rst_move", field_code, 1);
    reset = 1'b0; tick();
    chk("midrst_field", field_code, 15);
    chk("midrst_editing", editing, 0);
    chk("midrst_blink", blink, 0);
    reset = 1'b1; tick();
    chk("post_rst_idle", editing, 0);
    enter_edit(2'b00);
    chk("post_rst_first", field_code, 0);
    tick(); tick();
    chk("held_no_move", field_code, 0);
    btn_right = 1'b0; tick();
    press_right();
    chk("repress_move", field_code, 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/field_select_ctrl.md
FIELD_SELECT_CTRL -- requirements
Module: field_select_ctrl

Interface
REQ-001 SHALL have parameter BLINK_DIV, default 25_000_000, clock cycles per blink half-period.
REQ-002 SHALL have parameter TIMEOUT, default 500_000_000, idle cycles before automatic edit exit.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-005 SHALL have port mode_sel, input, 2, 00 = hour, 01 = date, 10 = chronometer, 11 = invalid.
REQ-006 SHALL have port edit_en, input, 1, level request to enter or stay in edit.
REQ-007 SHALL have ports btn_left, btn_right, btn_up, btn_down, input, 1 each, debounced button levels.
REQ-008 SHALL have port field_code, output, 4, field index in the flag-decoder encoding: 0-2 hour s/m/h, 3-5 date d/m/y, 7-9 chrono s/m/h, 4'b1111 = none.
REQ-009 SHALL have ports inc_pulse and dec_pulse, output, 1 each, single-cycle field adjust strobes.
REQ-010 SHALL have port blink, output, 1, display-blank phase for the selected field.
REQ-011 SHALL have port editing, output, 1, high while in EDIT.

Function
REQ-012 SHALL rising-edge-detect each button internally; a held button SHALL yield exactly one event.
REQ-013 SHALL implement FSM IDLE/EDIT: IDLE->EDIT on rising edge of edit_en with mode_sel != 11; EDIT->IDLE when edit_en = 0, mode_sel = 11, or timeout expires.
REQ-014 SHALL, on entering EDIT, set field_code to the group's seconds/day field (hour 0, date 3, chrono 7) on the following cycle.
REQ-015 SHALL drive field_code = 4'b1111, inc_pulse = 0, dec_pulse = 0, blink = 0, editing = 0 in IDLE.
REQ-016 SHALL, on a btn_right event in EDIT, advance field_code within its group and wrap last->first (2->0, 5->3, 9->7); btn_left SHALL step backward with the mirror-image wrap.
REQ-017 SHALL never emit field_code 6 or any value outside {0-5, 7-9, 15}.
REQ-018 SHALL ignore left and right events that occur in the same cycle; likewise for up and down in the same cycle.
REQ-019 SHALL assert inc_pulse (btn_up) or dec_pulse (btn_down) the cycle after the event, one cycle wide, only in EDIT; the two SHALL never be high together.
REQ-020 SHALL, on a mode_sel change (00/01/10) while in EDIT, reload field_code with the new group's first field next cycle and suppress any adjust strobe in that cycle.
REQ-021 SHALL toggle blink every BLINK_DIV cycles in EDIT; blink counter SHALL restart with blink = 0 on entering EDIT and on every cursor move.
REQ-022 SHALL count idle cycles in EDIT; any button event SHALL clear the count; reaching TIMEOUT-1 SHALL force IDLE next cycle.

Reset
REQ-023 SHALL, with reset = 0 at a clock edge, enter IDLE, clear all counters and edge-detect history, and drive outputs per REQ-015, regardless of in-progress activity.
REQ-024 SHALL NOT treat a button held through reset release as an event.

Configuration
REQ-025 SHALL compile the inactivity timeout (REQ-022) only when macro FIELD_TIMEOUT_EN is defined; without it there SHALL be no timeout counter and EDIT exits only via edit_en = 0 or mode_sel = 11.

Structure
REQ-026 SHALL take field-code constants (0-5, 7-9, NONE = 15), group first/last codes, mode_sel encodings, and FSM state encodings from shared package field_ctrl_pkg, which the flag decoder also uses.
REQ-027 SHALL instantiate one sub-module, btn_edge, four times, for button rising-edge detection.

Verification
REQ-028 Reset, then edit_en 0->1 with mode_sel = 01 -> editing = 1 and field_code = 3 on the second cycle after the edge.
REQ-029 Hour mode; three btn_right presses -> field_code 0->1->2->0; one btn_left -> 2; field_code never 6.
REQ-030 Chrono mode, field 8; btn_up held for 10 cycles -> exactly one inc_pulse; btn_up and btn_down rising together -> no pulse.
REQ-031 With BLINK_DIV = 4, TIMEOUT = 20, FIELD_TIMEOUT_EN defined: no buttons -> blink toggles every 4 cycles; editing = 0 and field_code = 15 after 20 idle cycles; undefined -> editing stays 1.
REQ-032 EDIT at field 5; mode_sel changes 01->10 -> field_code = 7 next cycle; mode_sel = 11 -> IDLE, field_code = 15.
REQ-033 reset pulsed low during EDIT with btn_right held -> IDLE outputs; after release, no cursor move until btn_right is released and pressed again.
